// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - byte-stream command front-end and result back-end for the 8-bit ALU
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [1:0]  alu_m,
  output logic [1:0]  alu_s,
  input  logic [15:0] alu_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  op_count
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("alu_sequencer: EXEC_CYCLES must be in 1..15");
  end

  localparam logic [3:0] EXEC_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    GET_X  = 3'd0,
    GET_Y  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    OUT_LO = 3'd4,
    OUT_HI = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [3:0]  exec_cnt;
  logic [15:0] result;
  logic        in_fire, out_fire;
  logic        unused_op_bits;

  // Opcode bits [7:4] carry no meaning for the ALU.
  assign unused_op_bits = ^in_data[7:4];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GET_X;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      GET_X:   if (in_fire) state_next = GET_Y;
      GET_Y:   if (in_fire) state_next = GET_OP;
      GET_OP:  if (in_fire) state_next = EXEC;
      EXEC:    if (exec_cnt == 4'd0) state_next = OUT_LO;
      OUT_LO:  if (out_fire) state_next = OUT_HI;
      OUT_HI:  if (out_fire) state_next = GET_X;
      default: state_next = GET_X;
    endcase
  end

  // All handshake outputs decode from the registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = 8'h00;
    case (state)
      GET_X, GET_Y, GET_OP: in_ready = 1'b1;
      EXEC:    busy = 1'b1;
      OUT_LO: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = result[7:0];
      end
      OUT_HI: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = result[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x    <= 8'h00;
      alu_y    <= 8'h00;
      alu_m    <= 2'b00;
      alu_s    <= 2'b00;
      exec_cnt <= 4'd0;
      result   <= 16'h0000;
      op_count <= 8'h00;
    end else begin
      case (state)
        GET_X:  if (in_fire) alu_x <= in_data;
        GET_Y:  if (in_fire) alu_y <= in_data;
        GET_OP: if (in_fire) begin
          alu_m    <= in_data[1:0];
          alu_s    <= in_data[3:2];
          exec_cnt <= EXEC_INIT;
        end
        EXEC: begin
          if (exec_cnt == 4'd0) result <= alu_z;
          else                  exec_cnt <= exec_cnt - 4'd1;
        end
        OUT_HI: if (out_fire) op_count <= op_count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer (EXEC_CYCLES 1 and 4)
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, busy;
  logic [7:0]  in_data = 8'h00, alu_x, alu_y, out_data, op_count;
  logic [1:0]  alu_m, alu_s;
  logic [15:0] alu_z;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_last4, busy4;
  logic [7:0]  in_data4 = 8'h00, alu_x4, alu_y4, out_data4, op_count4;
  logic [1:0]  alu_m4, alu_s4;
  logic [15:0] alu_z4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_z  = {alu_y, alu_x} ^ {12'h000, alu_s, alu_m};
  assign alu_z4 = {alu_y4, alu_x4} ^ {12'h000, alu_s4, alu_m4};

  alu_sequencer #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_s(alu_s), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .op_count(op_count)
  );

  alu_sequencer #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .alu_x(alu_x4), .alu_y(alu_y4), .alu_m(alu_m4), .alu_s(alu_s4), .alu_z(alu_z4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4),
    .busy(busy4), .op_count(op_count4)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 16'(in_ready), 16'h1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp_d, input logic exp_l);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 16'(out_valid), 16'h1);
    check({tag, "_data"}, 16'(out_data), 16'(exp_d));
    check({tag, "_last"}, 16'(out_last), 16'(exp_l));
    @(negedge clk);
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] op,
                       input logic [7:0] lo, input logic [7:0] hi);
    send_byte(x);
    send_byte(y);
    send_byte(op);
    recv_byte("op_lo", lo, 1'b0);
    recv_byte("op_hi", hi, 1'b1);
  endtask

  initial begin
    int lat;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_alu_x", 16'(alu_x), 16'h0);
    check("rst_op_count", 16'(op_count), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h0);

    // Single op: z = 3412 ^ 0006 = 3414
    out_ready = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h06);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lat_exec1", 16'(lat), 16'd2);
    check("single_alu_m", 16'(alu_m), 16'h2);
    check("single_alu_s", 16'(alu_s), 16'h1);
    check("single_lo", 16'(out_data), 16'h14);
    check("single_lo_last", 16'(out_last), 16'h0);
    @(negedge clk);
    check("single_hi", 16'(out_data), 16'h34);
    check("single_hi_last", 16'(out_last), 16'h1);
    @(negedge clk);
    check("single_count", 16'(op_count), 16'h1);
    check("single_idle_ready", 16'(in_ready), 16'h1);

    // Stalls on both channels
    out_ready = 1'b0;
    send_byte(8'h12);
    repeat (2) @(negedge clk);
    check("gap_in_ready", 16'(in_ready), 16'h1);
    send_byte(8'h34);
    repeat (3) @(negedge clk);
    send_byte(8'h06);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      check("stall_data", 16'(out_data), 16'h14);
      check("stall_valid", 16'(out_valid), 16'h1);
      check("stall_in_ready", 16'(in_ready), 16'h0);
      @(negedge clk);
    end
    check("stall_alu_x", 16'(alu_x), 16'h12);
    in_valid = 1'b0;
    recv_byte("stall_lo", 8'h14, 1'b0);
    recv_byte("stall_hi", 8'h34, 1'b1);
    check("stall_count", 16'(op_count), 16'h2);

    // EXEC_CYCLES=4: z = CDAB ^ 0009 = CDA2
    in_valid4 = 1'b1;
    in_data4  = 8'hAB;
    @(negedge clk);
    in_data4 = 8'hCD;
    @(negedge clk);
    in_data4 = 8'h09;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 20) begin
      check("e4_busy", 16'(busy4), 16'h1);
      check("e4_xy", {alu_y4, alu_x4}, 16'hCDAB);
      check("e4_ms", {12'h000, alu_s4, alu_m4}, 16'h0009);
      @(negedge clk);
      lat++;
    end
    check("lat_exec4", 16'(lat), 16'd5);
    out_ready4 = 1'b1;
    check("e4_lo", {7'h00, out_last4, out_data4}, 16'h00A2);
    @(negedge clk);
    check("e4_hi", {7'h00, out_last4, out_data4}, 16'h01CD);
    @(negedge clk);
    check("e4_count", 16'(op_count4), 16'h1);

    // Wrap: 254 more ops reach 256 total, then one more
    for (int i = 0; i < 254; i++) begin
      do_op(8'(i), ~8'(i), 8'h00, 8'(i), ~8'(i));
    end
    check("wrap_256", 16'(op_count), 16'h0);
    do_op(8'h5A, 8'hC3, 8'h03, 8'h59, 8'hC3);
    check("wrap_257", 16'(op_count), 16'h1);

    // Reset while in OUT_HI
    out_ready = 1'b0;
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h00);
    recv_byte("pre_rst_lo", 8'h77, 1'b0);
    out_ready = 1'b0;
    check("pre_rst_last", 16'(out_last), 16'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 16'(out_valid), 16'h0);
    check("mid_rst_out_data", 16'(out_data), 16'h0);
    check("mid_rst_busy", 16'(busy), 16'h0);
    check("mid_rst_in_ready", 16'(in_ready), 16'h1);
    check("mid_rst_op_count", 16'(op_count), 16'h0);
    check("mid_rst_alu_x", 16'(alu_x), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(8'hFF, 8'h01, 8'h0F, 8'hF0, 8'h01);
    check("post_rst_count", 16'(op_count), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
